// File: rtl/decoder_pkg.sv
// Shared opcode map, writeback/ALU select constants and the decoded control
// bundle carried through the decode queue.
package decoder_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_BRNZP = 4'h1;
  localparam logic [3:0] OP_CMP   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_DIV   = 4'h6;
  localparam logic [3:0] OP_LDR   = 4'h7;
  localparam logic [3:0] OP_STR   = 4'h8;
  localparam logic [3:0] OP_CONST = 4'h9;
  localparam logic [3:0] OP_FMA   = 4'hA;
  localparam logic [3:0] OP_ACT   = 4'hB;
  localparam logic [3:0] OP_RET   = 4'hF;

  localparam logic [2:0] REG_MUX_ALU   = 3'b000;
  localparam logic [2:0] REG_MUX_MEM   = 3'b001;
  localparam logic [2:0] REG_MUX_CONST = 3'b010;
  localparam logic [2:0] REG_MUX_FMA   = 3'b011;
  localparam logic [2:0] REG_MUX_ACT   = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [2:0] nzp;
    logic [7:0] imm;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       nzp_we;
    logic [2:0] reg_mux;
    logic [1:0] alu_arith;
    logic       alu_out_mux;
    logic       pc_mux;
    logic       fma_en;
    logic       act_en;
    logic [1:0] act_func;
    logic       ret;
    logic       illegal;
  } decoded_t;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: 16-bit instruction to control
// bundle. Register/immediate fields are extracted for every opcode.
module decode_comb
  import decoder_pkg::*;
(
  input  logic [15:0] i_instr,
  output decoded_t    o_dec,
  output logic        o_illegal
);

  always_comb begin
    o_dec     = '0;
    o_illegal = 1'b0;
    o_dec.rd  = i_instr[11:8];
    o_dec.rs  = i_instr[7:4];
    o_dec.rt  = i_instr[3:0];
    o_dec.imm = i_instr[7:0];
    o_dec.nzp = i_instr[11:9];
    case (i_instr[15:12])
      OP_NOP: ;
      OP_BRNZP: o_dec.pc_mux = 1'b1;
      OP_CMP: begin
        o_dec.rs          = i_instr[11:8];
        o_dec.rt          = i_instr[7:4];
        o_dec.alu_out_mux = 1'b1;
        o_dec.nzp_we      = 1'b1;
      end
      OP_ADD: begin o_dec.reg_we = 1'b1; o_dec.alu_arith = ALU_ADD; end
      OP_SUB: begin o_dec.reg_we = 1'b1; o_dec.alu_arith = ALU_SUB; end
      OP_MUL: begin o_dec.reg_we = 1'b1; o_dec.alu_arith = ALU_MUL; end
      OP_DIV: begin o_dec.reg_we = 1'b1; o_dec.alu_arith = ALU_DIV; end
      OP_LDR: begin
        o_dec.reg_we  = 1'b1;
        o_dec.reg_mux = REG_MUX_MEM;
        o_dec.mem_re  = 1'b1;
      end
      OP_STR: begin
        o_dec.rs     = i_instr[11:8];
        o_dec.rt     = i_instr[7:4];
        o_dec.mem_we = 1'b1;
      end
      OP_CONST: begin o_dec.reg_we = 1'b1; o_dec.reg_mux = REG_MUX_CONST; end
      OP_FMA: begin
        o_dec.reg_we  = 1'b1;
        o_dec.reg_mux = REG_MUX_FMA;
        o_dec.fma_en  = 1'b1;
      end
      OP_ACT: begin
        o_dec.reg_we   = 1'b1;
        o_dec.reg_mux  = REG_MUX_ACT;
        o_dec.act_en   = 1'b1;
        o_dec.act_func = i_instr[9:8];
      end
      OP_RET: o_dec.ret = 1'b1;
      default: begin
        // 1100..1110: no controls asserted, only the illegal marker
        o_dec.illegal = 1'b1;
        o_illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Flow-controlled decoder: decodes on intake, buffers DEPTH control bundles,
// halts on RET/illegal. Optional DECODE_QUEUE_PERF_EN adds perf counters.
module decode_queue
  import decoder_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int DEPTH        = 2,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_instruction,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [3:0]          out_rd,
  output logic [3:0]          out_rs,
  output logic [3:0]          out_rt,
  output logic [2:0]          out_nzp,
  output logic [7:0]          out_imm,
  output logic                out_reg_we,
  output logic                out_mem_re,
  output logic                out_mem_we,
  output logic                out_nzp_we,
  output logic [2:0]          out_reg_mux,
  output logic [1:0]          out_alu_arith,
  output logic                out_alu_out_mux,
  output logic                out_pc_mux,
  output logic                out_fma_en,
  output logic                out_act_en,
  output logic [1:0]          out_act_func,
  output logic                out_ret,
  output logic                out_illegal,
`ifdef DECODE_QUEUE_PERF_EN
  output logic [31:0]         perf_decoded,
  output logic [31:0]         perf_stall,
`endif
  output logic                halted,
  output logic                err_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]       r_count;
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  decoded_t            r_mem    [DEPTH];
  logic [PC_WIDTH-1:0] r_pc_mem [DEPTH];
  state_t              r_state, w_state_nxt;
  logic                r_err;
  decoded_t            w_dec, w_head;
  logic                w_illegal, w_push, w_pop;

  decode_comb u_decode_comb (
    .i_instr   (in_instruction),
    .o_dec     (w_dec),
    .o_illegal (w_illegal)
  );

  assign in_ready  = (r_state == ST_RUN) && (r_count < DEPTH_C) && !reset;
  assign out_valid = (r_count != '0);
  // flush discards whatever handshakes happen in its cycle
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= ST_RUN;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push && w_illegal) r_err <= 1'b1;
      if (flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]    <= w_dec;
      r_pc_mem[r_wr_ptr] <= in_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = ST_RUN;
    else if (w_push && (w_dec.ret || (w_illegal && (ILLEGAL_HALT != 0))))
      w_state_nxt = ST_HALTED;
  end

  assign halted      = (r_state == ST_HALTED);
  assign err_illegal = r_err;

  // empty head reads as all zeros
  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_pc = out_valid ? r_pc_mem[r_rd_ptr] : '0;

  assign out_rd          = w_head.rd;
  assign out_rs          = w_head.rs;
  assign out_rt          = w_head.rt;
  assign out_nzp         = w_head.nzp;
  assign out_imm         = w_head.imm;
  assign out_reg_we      = w_head.reg_we;
  assign out_mem_re      = w_head.mem_re;
  assign out_mem_we      = w_head.mem_we;
  assign out_nzp_we      = w_head.nzp_we;
  assign out_reg_mux     = w_head.reg_mux;
  assign out_alu_arith   = w_head.alu_arith;
  assign out_alu_out_mux = w_head.alu_out_mux;
  assign out_pc_mux      = w_head.pc_mux;
  assign out_fma_en      = w_head.fma_en;
  assign out_act_en      = w_head.act_en;
  assign out_act_func    = w_head.act_func;
  assign out_ret         = w_head.ret;
  assign out_illegal     = w_head.illegal;

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] r_perf_decoded, r_perf_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_decoded <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push && (r_perf_decoded != '1))
        r_perf_decoded <= r_perf_decoded + 1'b1;
      if (in_valid && !in_ready && (r_state == ST_RUN) && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_decoded = r_perf_decoded;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_decode_queue;

  localparam int PC_WIDTH     = 8;
  localparam int DEPTH        = 2;
  localparam int ILLEGAL_HALT = 0;

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] rd, rs, rt;
    logic [2:0] nzp;
    logic [7:0] imm;
    logic       reg_we, mem_re, mem_we, nzp_we;
    logic [2:0] reg_mux;
    logic [1:0] alu_arith;
    logic       alu_out_mux, pc_mux, fma_en, act_en;
    logic [1:0] act_func;
    logic       ret, illegal;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [15:0] in_instruction = '0;
  logic [PC_WIDTH-1:0] in_pc = '0;
  logic in_ready, out_valid, halted, err_illegal;
  logic [PC_WIDTH-1:0] out_pc;
  logic [3:0] out_rd, out_rs, out_rt;
  logic [2:0] out_nzp, out_reg_mux;
  logic [7:0] out_imm;
  logic out_reg_we, out_mem_re, out_mem_we, out_nzp_we;
  logic [1:0] out_alu_arith, out_act_func;
  logic out_alu_out_mux, out_pc_mux, out_fma_en, out_act_en, out_ret, out_illegal;
`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] perf_decoded, perf_stall;
`endif

  int n_chk = 0, n_err = 0;
  exp_t sb_q[$];
  logic m_halted = 1'b0, m_err = 1'b0;

  decode_queue #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .ILLEGAL_HALT(ILLEGAL_HALT)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_nzp(out_nzp),
    .out_imm(out_imm), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
    .out_mem_we(out_mem_we), .out_nzp_we(out_nzp_we), .out_reg_mux(out_reg_mux),
    .out_alu_arith(out_alu_arith), .out_alu_out_mux(out_alu_out_mux),
    .out_pc_mux(out_pc_mux), .out_fma_en(out_fma_en), .out_act_en(out_act_en),
    .out_act_func(out_act_func), .out_ret(out_ret), .out_illegal(out_illegal),
`ifdef DECODE_QUEUE_PERF_EN
    .perf_decoded(perf_decoded), .perf_stall(perf_stall),
`endif
    .halted(halted), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t dut_vec();
    return {out_pc, out_rd, out_rs, out_rt, out_nzp, out_imm, out_reg_we, out_mem_re,
            out_mem_we, out_nzp_we, out_reg_mux, out_alu_arith, out_alu_out_mux,
            out_pc_mux, out_fma_en, out_act_en, out_act_func, out_ret, out_illegal};
  endfunction

  // Reference decode from the opcode table
  function automatic exp_t ref_decode(input logic [15:0] ins, input logic [7:0] pc);
    exp_t e = '0;
    int op = int'(ins[15:12]);
    e.pc = pc; e.rd = ins[11:8]; e.rs = ins[7:4]; e.rt = ins[3:0];
    e.imm = ins[7:0]; e.nzp = ins[11:9];
    if (op == 1) e.pc_mux = 1'b1;
    if (op == 2 || op == 8) begin e.rs = ins[11:8]; e.rt = ins[7:4]; end
    if (op == 2) begin e.alu_out_mux = 1'b1; e.nzp_we = 1'b1; end
    if (op >= 3 && op <= 6) begin e.reg_we = 1'b1; e.alu_arith = 2'(op - 3); end
    if (op == 7) begin e.reg_we = 1'b1; e.reg_mux = 3'd1; e.mem_re = 1'b1; end
    if (op == 8) e.mem_we = 1'b1;
    if (op >= 9 && op <= 11) begin e.reg_we = 1'b1; e.reg_mux = 3'(op - 7); end
    if (op == 10) e.fma_en = 1'b1;
    if (op == 11) begin e.act_en = 1'b1; e.act_func = ins[9:8]; end
    if (op >= 12 && op <= 14) e.illegal = 1'b1;
    if (op == 15) e.ret = 1'b1;
    return e;
  endfunction

  // Monitor: predicts the coming edge from the inputs held this cycle
  always @(negedge clk) begin
    bit exp_ready;
    exp_t e;
    if (rst) begin
      sb_q.delete(); m_halted = 1'b0; m_err = 1'b0;
    end
    exp_ready = !rst && !m_halted && (sb_q.size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("err_illegal", 64'(err_illegal), 64'(m_err));
    if (sb_q.size() == 0) chk("empty_mask", 64'(dut_vec()), 64'd0);
    if (!rst && flush) begin
      sb_q.delete(); m_halted = 1'b0;
    end else if (!rst) begin
      if (sb_q.size() != 0 && out_ready) begin
        e = sb_q.pop_front();
        chk("head", 64'(dut_vec()), 64'(e));
      end
      if (in_valid && exp_ready) begin
        e = ref_decode(in_instruction, in_pc);
        sb_q.push_back(e);
        if (e.illegal) m_err = 1'b1;
        if (e.ret || (e.illegal && ILLEGAL_HALT != 0)) m_halted = 1'b1;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    cyc(3);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outs", 64'(dut_vec()), 64'd0);
    rst = 1'b0;

    // field decode
    out_ready = 1'b1; in_valid = 1'b1; in_instruction = 16'h3123; in_pc = 8'h10;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_fields", 64'({out_rd, out_rs, out_rt, out_reg_we, out_reg_mux, out_alu_arith}),
        64'({4'd1, 4'd2, 4'd3, 1'b1, 3'b000, 2'b00}));
    cyc();

    // remaps
    in_valid = 1'b1; in_instruction = 16'h2450; in_pc = 8'h11;
    cyc();
    in_instruction = 16'hB512; in_pc = 8'h12;
    @(negedge clk);
    chk("cmp_fields", 64'({out_rs, out_rt, out_nzp_we, out_alu_out_mux}),
        64'({4'd4, 4'd5, 1'b1, 1'b1}));
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("act_fields", 64'({out_act_en, out_reg_mux, out_act_func}), 64'({1'b1, 3'b100, 2'b01}));
    cyc(2);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_instruction = 16'h9105; in_pc = 8'h20;
    cyc();
    in_instruction = 16'h9207; in_pc = 8'h21;
    cyc();
    in_instruction = 16'h3123; in_pc = 8'h22;
    @(negedge clk);
    chk("bp_full", 64'(in_ready), 64'd0);
    cyc(2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_imm0", 64'(out_imm), 64'h05);
    cyc();
    @(negedge clk);
    chk("bp_imm1", 64'(out_imm), 64'h07);
    chk("bp_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    cyc(2);

    // halt on RET
    out_ready = 1'b0; in_valid = 1'b1; in_instruction = 16'hF000; in_pc = 8'h30;
    cyc();
    in_instruction = 16'h3123; in_pc = 8'h31;
    @(negedge clk);
    chk("ret_head", 64'(out_ret), 64'd1);
    chk("halt_ready", 64'(in_ready), 64'd0);
    cyc(3);
    out_ready = 1'b1;
    cyc(3);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_halted", 64'(halted), 64'd0);
    cyc();
    in_valid = 1'b0;
    cyc(2);

    // illegal
    in_valid = 1'b1; in_instruction = 16'hC000; in_pc = 8'h40;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_head", 64'(out_illegal), 64'd1);
    chk("illegal_err", 64'(err_illegal), 64'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("err_sticky", 64'(err_illegal), 64'd1);
    cyc();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      in_instruction = 16'($urandom);
      in_pc          = 8'($urandom);
      out_ready      = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 19) == 0);
      cyc();
    end

    // reset mid-stream with two entries queued
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b1; in_instruction = 16'h9105; in_pc = 8'h50;
    cyc();
    in_instruction = 16'h9207; in_pc = 8'h51;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_outs", 64'(dut_vec()), 64'd0);
    chk("mid_rst_flags", 64'({in_ready, halted, err_illegal}), 64'd0);
`ifdef DECODE_QUEUE_PERF_EN
    chk("mid_rst_perf", 64'({perf_decoded, perf_stall}), 64'd0);
`endif
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
